// File: rtl/demultiplexor_pkg.sv
// Shared constants and types for the registered 1:2 stream demultiplexor.
package demultiplexor_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry channel buffer: two data registers, occupancy and a read pointer.
module demux_fifo2
  import demultiplexor_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [N-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         valid,
  output logic [N-1:0] head_data
);

  logic [N-1:0] mem [DEPTH];
  occ_t         occ;
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign valid     = (occ != EMPTY);
  assign full      = (occ == FULL);
  assign head_data = mem[rd_ptr];

  // When full with a simultaneous pop, the write lands in the slot being freed.
  assign wr_ptr  = rd_ptr ^ (occ == ONE);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      occ    <= EMPTY;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push)
        mem[wr_ptr] <= push_data;
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   occ <= (occ == EMPTY) ? ONE : FULL;
        2'b01:   occ <= (occ == FULL) ? ONE : EMPTY;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/demultiplexor.sv
// Registered 1:2 stream demultiplexor with per-channel buffers and transfer counters.
module demultiplexor
  import demultiplexor_pkg::*;
#(
  parameter int N  = 5,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sel,
  input  logic [N-1:0]  in_data,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [N-1:0]  out0_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [N-1:0]  out1_data,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;
  logic pop0;
  logic pop1;

  // Ready depends only on the addressed channel's state, never on out ready.
  assign in_ready = !rst && ((sel == CH1) ? !full1 : !full0);
  assign push0    = in_valid && in_ready && (sel == CH0);
  assign push1    = in_valid && in_ready && (sel == CH1);
  assign pop0     = out0_valid && out0_ready;
  assign pop1     = out1_valid && out1_ready;

  demux_fifo2 #(.N(N)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .full      (full0),
    .valid     (out0_valid),
    .head_data (out0_data)
  );

  demux_fifo2 #(.N(N)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .full      (full1),
    .valid     (out1_valid),
    .head_data (out1_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0)
        cnt0 <= cnt0 + 1'b1;
      if (pop1)
        cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_demultiplexor.sv
// Directed self-checking bench for the demultiplexor, with a 3-bit counter to reach wrap.
module tb_demultiplexor;

  localparam int N  = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          sel;
  logic [N-1:0]  in_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [N-1:0]  out0_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [N-1:0]  out1_data;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int compared   = 0;
  int mismatched = 0;

  demultiplexor #(.N(N), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [N-1:0] d);
    in_valid = v;
    sel      = s;
    in_data  = d;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #1;
    checkOutput("rst_in_ready", 8'(in_ready), 8'd0);
    checkOutput("rst_out0_valid", 8'(out0_valid), 8'd0);
    checkOutput("rst_out1_valid", 8'(out1_valid), 8'd0);
    checkOutput("rst_out0_data", 8'(out0_data), 8'h00);
    checkOutput("rst_cnt0", 8'(cnt0), 8'd0);
    checkOutput("rst_cnt1", 8'(cnt1), 8'd0);
    tick();
    rst = 1'b0;

    // Route to ch0
    out0_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'h15);
    checkOutput("t1_in_ready", 8'(in_ready), 8'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'h00);
    checkOutput("t1_out0_valid", 8'(out0_valid), 8'd1);
    checkOutput("t1_out0_data", 8'(out0_data), 8'h15);
    checkOutput("t1_out1_valid", 8'(out1_valid), 8'd0);
    checkOutput("t1_cnt0_pre", 8'(cnt0), 8'd0);
    tick();
    checkOutput("t1_out0_valid_after", 8'(out0_valid), 8'd0);
    checkOutput("t1_cnt0", 8'(cnt0), 8'd1);

    // Route to ch1
    out1_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'h0A);
    tick();
    applyStimulus(1'b0, 1'b1, 5'h00);
    checkOutput("t2_out1_valid", 8'(out1_valid), 8'd1);
    checkOutput("t2_out1_data", 8'(out1_data), 8'h0A);
    checkOutput("t2_out0_valid", 8'(out0_valid), 8'd0);
    tick();
    checkOutput("t2_cnt1", 8'(cnt1), 8'd1);
    checkOutput("t2_cnt0", 8'(cnt0), 8'd1);
    checkOutput("t2_out1_valid_after", 8'(out1_valid), 8'd0);

    // Backpressure isolation
    out0_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 5'h15);
    tick();
    applyStimulus(1'b1, 1'b0, 5'h0A);
    tick();
    applyStimulus(1'b1, 1'b0, 5'h0A);
    checkOutput("t3_full_in_ready", 8'(in_ready), 8'd0);
    checkOutput("t3_out0_head", 8'(out0_data), 8'h15);
    applyStimulus(1'b1, 1'b1, 5'h1F);
    checkOutput("t3_other_in_ready", 8'(in_ready), 8'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 5'h00);
    checkOutput("t3_out1_valid", 8'(out1_valid), 8'd1);
    checkOutput("t3_out1_data", 8'(out1_data), 8'h1F);
    checkOutput("t3_out0_held", 8'(out0_data), 8'h15);
    out0_ready = 1'b1;
    tick();
    checkOutput("t3_drain2_valid", 8'(out0_valid), 8'd1);
    checkOutput("t3_drain2_data", 8'(out0_data), 8'h0A);
    checkOutput("t3_cnt0", 8'(cnt0), 8'd2);
    checkOutput("t3_cnt1", 8'(cnt1), 8'd2);
    tick();
    checkOutput("t3_cnt0_done", 8'(cnt0), 8'd3);
    checkOutput("t3_out0_empty", 8'(out0_valid), 8'd0);

    // Full push with simultaneous pop
    out0_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 5'h01);
    tick();
    applyStimulus(1'b1, 1'b0, 5'h02);
    tick();
    out0_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'h03);
    checkOutput("t4_full_in_ready", 8'(in_ready), 8'd0);
    checkOutput("t4_head_01", 8'(out0_data), 8'h01);
    tick();
    checkOutput("t4_head_02", 8'(out0_data), 8'h02);
    checkOutput("t4_in_ready", 8'(in_ready), 8'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'h00);
    checkOutput("t4_head_03_valid", 8'(out0_valid), 8'd1);
    checkOutput("t4_head_03", 8'(out0_data), 8'h03);
    tick();
    checkOutput("t4_empty", 8'(out0_valid), 8'd0);
    checkOutput("t4_cnt0", 8'(cnt0), 8'd6);

    // Counter wrap on ch1, starting from a clean reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b1, 5'(i + 8));
      tick();
      applyStimulus(1'b0, 1'b1, 5'h00);
      checkOutput("t5_data", 8'(out1_data), 8'(i + 8));
      tick();
      if (i == 7) checkOutput("t5_cnt1_7", 8'(cnt1), 8'd7);
      if (i == 8) checkOutput("t5_cnt1_wrap", 8'(cnt1), 8'd0);
    end
    checkOutput("t5_cnt1_after", 8'(cnt1), 8'd1);

    // Asynchronous reset in mid-operation
    out1_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'h1C);
    tick();
    applyStimulus(1'b1, 1'b1, 5'h1D);
    tick();
    applyStimulus(1'b0, 1'b1, 5'h00);
    checkOutput("t6_pre_valid", 8'(out1_valid), 8'd1);
    checkOutput("t6_pre_in_ready", 8'(in_ready), 8'd0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_valid", 8'(out1_valid), 8'd0);
    checkOutput("t6_rst_cnt1", 8'(cnt1), 8'd0);
    checkOutput("t6_rst_in_ready", 8'(in_ready), 8'd0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t6_rel_in_ready", 8'(in_ready), 8'd1);
    applyStimulus(1'b1, 1'b1, 5'h11);
    checkOutput("t6_no_early_out", 8'(out1_valid), 8'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 5'h00);
    checkOutput("t6_new_valid", 8'(out1_valid), 8'd1);
    checkOutput("t6_new_data", 8'(out1_data), 8'h11);
    out1_ready = 1'b1;
    tick();
    checkOutput("t6_new_popped", 8'(out1_valid), 8'd0);
    checkOutput("t6_new_cnt1", 8'(cnt1), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
